// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the AXI-Stream mux arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Width of a field that must hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = bits_for(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    always_comb begin : pick
        logic [IW:0]   w_sum;
        logic [IW-1:0] w_idx;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        o_vld = 1'b0;
        o_idx = '0;
        w_sum = '0;
        w_idx = '0;
        // Walk from lowest priority to highest so the last hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(N)) begin
                w_sum = w_sum - (IW + 1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (i_req[w_idx]) begin
                o_vld = 1'b1;
                o_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/axis_mux_arbiter.sv
// Round-robin arbiter driving an AXI-Stream mux select, with per-grant burst limit.
module axis_mux_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int PORT_NUM  = 4,
    parameter  int MAX_BURST = 16,
    localparam int IW        = bits_for(PORT_NUM),
    localparam int CW        = bits_for(MAX_BURST + 1)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [PORT_NUM-1:0] s_axi_vld_i,
    input  logic                m_axi_rdy_i,
    output logic [PORT_NUM-1:0] mux_ctrl_o,
    output logic [IW-1:0]       grant_idx_o,
    output logic                busy_o,
    output logic [CW-1:0]       beat_cnt_o
);

    state_e              r_state,     w_state_nxt;
    logic [PORT_NUM-1:0] r_mux_ctrl,  w_mux_ctrl_nxt;
    logic [IW-1:0]       r_grant_idx, w_grant_idx_nxt;
    logic [IW-1:0]       r_ptr,       w_ptr_nxt;
    logic                r_busy,      w_busy_nxt;
    logic [CW-1:0]       r_beat_cnt,  w_beat_cnt_nxt;
    logic                r_arm;

    logic                w_pick_vld;
    logic [IW-1:0]       w_pick_idx;
    logic                w_gnt_vld;
    logic                w_beat;
    logic                w_last;

    rr_pick #(
        .N  (PORT_NUM),
        .IW (IW)
    ) u_rr_pick (
        .i_req (s_axi_vld_i),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    assign w_gnt_vld = s_axi_vld_i[r_grant_idx];
    assign w_beat    = (r_state == GRANT) && w_gnt_vld && m_axi_rdy_i;
    assign w_last    = w_beat && (r_beat_cnt == CW'(MAX_BURST - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_mux_ctrl_nxt  = r_mux_ctrl;
        w_grant_idx_nxt = r_grant_idx;
        w_busy_nxt      = r_busy;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            IDLE: begin
                if (r_arm && w_pick_vld) begin
                    w_state_nxt                = GRANT;
                    w_mux_ctrl_nxt             = '0;
                    w_mux_ctrl_nxt[w_pick_idx] = 1'b1;
                    w_grant_idx_nxt            = w_pick_idx;
                    w_busy_nxt                 = 1'b1;
                    w_beat_cnt_nxt             = '0;
                end
            end
            GRANT: begin
                if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                end
                if (w_last || !w_gnt_vld) begin
                    w_state_nxt    = IDLE;
                    w_mux_ctrl_nxt = '0;
                    w_busy_nxt     = 1'b0;
                    w_ptr_nxt      = (r_grant_idx == IW'(PORT_NUM - 1)) ? '0
                                                                       : r_grant_idx + IW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_mux_ctrl  <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
            r_beat_cnt  <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mux_ctrl  <= w_mux_ctrl_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    // Arbitration stays disabled for the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_arm <= 1'b0;
        end else begin
            r_arm <= 1'b1;
        end
    end

    assign mux_ctrl_o  = r_mux_ctrl;
    assign grant_idx_o = r_grant_idx;
    assign busy_o      = r_busy;
    assign beat_cnt_o  = r_beat_cnt;

endmodule

// File: tb/tb_axis_mux_arbiter.sv
// Directed, table-driven bench for axis_mux_arbiter with PORT_NUM = 4, MAX_BURST = 4.
module tb_axis_mux_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [3:0] s_axi_vld_i;
    logic       m_axi_rdy_i;
    logic [3:0] mux_ctrl_o;
    logic [1:0] grant_idx_o;
    logic       busy_o;
    logic [2:0] beat_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] mux;
        logic       busy;
        logic [1:0] idx;
        logic [2:0] cnt;
        bit         chk_cnt;
    } vec_t;

    vec_t tbl[$];

    axis_mux_arbiter #(
        .PORT_NUM  (4),
        .MAX_BURST (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .s_axi_vld_i (s_axi_vld_i),
        .m_axi_rdy_i (m_axi_rdy_i),
        .mux_ctrl_o  (mux_ctrl_o),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o),
        .beat_cnt_o  (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] mux, input logic busy,
                              input logic [1:0] idx, input logic [2:0] cnt, input bit chk_cnt);
        check({tag, ".mux"},    32'(mux_ctrl_o),  32'(mux));
        check({tag, ".busy"},   32'(busy_o),      32'(busy));
        check({tag, ".idx"},    32'(grant_idx_o), 32'(idx));
        check({tag, ".onehot"}, 32'($countones(mux_ctrl_o) <= 1), 32'(1));
        if (chk_cnt) begin
            check({tag, ".cnt"}, 32'(beat_cnt_o), 32'(cnt));
        end
    endtask

    task automatic step(input logic [3:0] vld, input logic rdy);
        s_axi_vld_i = vld;
        m_axi_rdy_i = rdy;
        @(posedge clk_i);
        #1;
    endtask

    function automatic void add_row(input logic [3:0] vld, input logic rdy, input logic [3:0] mux,
                                    input logic busy, input logic [1:0] idx, input logic [2:0] cnt,
                                    input bit chk_cnt);
        vec_t v;
        v.vld = vld; v.rdy = rdy; v.mux = mux; v.busy = busy;
        v.idx = idx; v.cnt = cnt; v.chk_cnt = chk_cnt;
        tbl.push_back(v);
    endfunction

    // Full 4-beat burst with ready high: grant row, three beat rows, then the idle gap row.
    function automatic void add_burst(input logic [3:0] vld, input int port);
        logic [3:0] oh;
        oh = 4'b0001 << port;
        add_row(vld, 1'b1, oh, 1'b1, 2'(port), 3'd0, 1'b1);
        add_row(vld, 1'b1, oh, 1'b1, 2'(port), 3'd1, 1'b1);
        add_row(vld, 1'b1, oh, 1'b1, 2'(port), 3'd2, 1'b1);
        add_row(vld, 1'b1, oh, 1'b1, 2'(port), 3'd3, 1'b1);
        add_row(vld, 1'b1, 4'b0000, 1'b0, 2'(port), 3'd0, 1'b0);
    endfunction

    initial begin
        // All ports valid: rotate 0,1,2,3 and back to 0.
        add_burst(4'b1111, 0);
        add_burst(4'b1111, 1);
        add_burst(4'b1111, 2);
        add_burst(4'b1111, 3);
        add_burst(4'b1111, 0);
        // Only port 2 valid: regranted after a single idle cycle.
        add_burst(4'b0100, 2);
        add_burst(4'b0100, 2);

        s_axi_vld_i = 4'b0000;
        m_axi_rdy_i = 1'b0;
        rst_n_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_outs("reset_held", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1);

        rst_n_i = 1'b1;
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check_outs("idle_no_req", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].rdy);
            check_outs($sformatf("vec%0d", i), tbl[i].mux, tbl[i].busy, tbl[i].idx,
                       tbl[i].cnt, tbl[i].chk_cnt);
        end

        // Reset in the middle of a port-3 burst (pointer is 3 after the port-2 bursts).
        step(4'b1000, 1'b1);
        check_outs("p3_grant", 4'b1000, 1'b1, 2'd3, 3'd0, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        check_outs("p3_beat2", 4'b1000, 1'b1, 2'd3, 3'd2, 1'b1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_outs("rst_async", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1);
        s_axi_vld_i = 4'b1111;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        step(4'b1111, 1'b1);
        check_outs("no_arb_on_release", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1);
        step(4'b1111, 1'b0);
        check_outs("first_after_reset", 4'b0001, 1'b1, 2'd0, 3'd0, 1'b1);

        // Backpressure: grant and count hold with ready low.
        for (int c = 0; c < 10; c++) begin
            step(4'b1111, 1'b0);
            check_outs($sformatf("stall%0d", c), 4'b0001, 1'b1, 2'd0, 3'd0, 1'b1);
        end
        step(4'b1111, 1'b1);
        check_outs("resume1", 4'b0001, 1'b1, 2'd0, 3'd1, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        check_outs("resume3", 4'b0001, 1'b1, 2'd0, 3'd3, 1'b1);
        step(4'b1111, 1'b1);
        check_outs("resume_release", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0);

        // Port 1 drops valid after two beats; pointer 2 skips idle port 2.
        step(4'b1010, 1'b1);
        check_outs("p1_grant", 4'b0010, 1'b1, 2'd1, 3'd0, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b1);
        check_outs("p1_beat2", 4'b0010, 1'b1, 2'd1, 3'd2, 1'b1);
        step(4'b1000, 1'b1);
        check_outs("p1_drop_release", 4'b0000, 1'b0, 2'd1, 3'd2, 1'b1);
        step(4'b1000, 1'b1);
        check_outs("p3_after_skip", 4'b1000, 1'b1, 2'd3, 3'd0, 1'b1);

        // A new request on port 0 mid-grant does not disturb port 3.
        step(4'b1001, 1'b1);
        check_outs("ignore_other1", 4'b1000, 1'b1, 2'd3, 3'd1, 1'b1);
        step(4'b1001, 1'b1);
        check_outs("ignore_other2", 4'b1000, 1'b1, 2'd3, 3'd2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
